// File: rtl/rib_uart_pkg.sv
// rib_uart_pkg: register offsets, CTRL/STATUS bit indices and FSM encodings shared by the UART.
package rib_uart_pkg;
    localparam logic [7:0] UART_CTRL   = 8'h00;
    localparam logic [7:0] UART_STATUS = 8'h04;
    localparam logic [7:0] UART_BAUD   = 8'h08;
    localparam logic [7:0] UART_TXDATA = 8'h0C;
    localparam logic [7:0] UART_RXDATA = 8'h10;
    localparam logic [7:0] UART_RXPOP  = 8'h14;
    localparam int CTRL_TX_EN = 0;
    localparam int CTRL_RX_EN = 1;
    localparam int CTRL_RX_IE = 2;
    localparam int CTRL_TX_IE = 3;
    localparam int STAT_RX_OVERRUN = 4;
    localparam int STAT_FRAME_ERR  = 5;
    localparam logic [15:0] BAUD_MIN = 16'd4;
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;
    function automatic logic [15:0] eff_baud(input logic [15:0] n);
        return (n < BAUD_MIN) ? BAUD_MIN : n;
    endfunction
endpackage

// File: rtl/rib_uart_fifo.sv
// uart_fifo: circular FIFO with a combinational head; a pop frees room for a same-cycle push.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [CW-1:0]    r_cnt;
    logic             w_pop;
    logic             w_push;
    assign full   = r_cnt == CW'(DEPTH);
    assign empty  = r_cnt == '0;
    assign dout   = r_mem[r_rp];
    assign w_pop  = pop & !empty;
    assign w_push = push & (!full | w_pop);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= din;
    end
endmodule

// File: rtl/rib_uart.sv
// rib_uart: RIB slave UART with 8N1 TX/RX FSMs, 4-entry FIFOs, baud divisor and level interrupt.
module rib_uart
    import rib_uart_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] BAUD_RST   = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic        we_i,
    output logic [31:0] data_o,
    output logic        tx_pin,
    input  logic        rx_pin,
    output logic        irq_o
);
    logic [3:0]  r_ctrl;
    logic [15:0] r_baud;
    logic        r_ovr;
    logic        r_ferr;
    logic        r_irq;
    logic [7:0]  w_addr;
    logic        w_wr_status;
    logic        w_wr_txdata;
    logic        w_wr_rxpop;
    logic        w_unused;
    assign w_addr      = addr_i[7:0];
    assign w_wr_status = we_i & (w_addr == UART_STATUS);
    assign w_wr_txdata = we_i & (w_addr == UART_TXDATA);
    assign w_wr_rxpop  = we_i & (w_addr == UART_RXPOP);
    assign w_unused    = ^{addr_i[31:8], data_i[31:16]};
    logic [7:0] w_tx_dout;
    logic [7:0] w_rx_dout;
    logic       w_tx_full, w_tx_empty, w_tx_pop;
    logic       w_rx_full, w_rx_empty, w_rx_push, w_rx_ferr;
    // TX writes into a full FIFO are dropped even if the FSM pops that cycle
    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(w_wr_txdata & !w_tx_full), .din(data_i[7:0]),
        .pop(w_tx_pop), .dout(w_tx_dout), .full(w_tx_full), .empty(w_tx_empty)
    );
    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(w_rx_push), .din(r_rx_sh),
        .pop(w_wr_rxpop), .dout(w_rx_dout), .full(w_rx_full), .empty(w_rx_empty)
    );
    uart_state_t r_tx_st, w_tx_nx;
    logic [15:0] r_tx_cnt, r_tx_n;
    logic [2:0]  r_tx_bit;
    logic [7:0]  r_tx_sh;
    logic        w_tx_tick, w_tx_go;
    assign w_tx_tick = r_tx_cnt == r_tx_n - 16'd1;
    assign w_tx_go   = r_ctrl[CTRL_TX_EN] & !w_tx_empty;
    assign tx_pin    = (r_tx_st == S_START) ? 1'b0 : (r_tx_st == S_DATA) ? r_tx_sh[0] : 1'b1;
    always_comb begin
        w_tx_nx  = r_tx_st;
        w_tx_pop = 1'b0;
        case (r_tx_st)
            S_IDLE:  if (w_tx_go) begin w_tx_nx = S_START; w_tx_pop = 1'b1; end
            S_START: if (w_tx_tick) w_tx_nx = S_DATA;
            S_DATA:  if (w_tx_tick && r_tx_bit == 3'd7) w_tx_nx = S_STOP;
            S_STOP:  if (w_tx_tick) begin w_tx_nx = w_tx_go ? S_START : S_IDLE; w_tx_pop = w_tx_go; end
            default: w_tx_nx = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_st  <= S_IDLE;
            r_tx_cnt <= '0;
            r_tx_n   <= eff_baud(BAUD_RST);
            r_tx_bit <= '0;
            r_tx_sh  <= '0;
        end else begin
            r_tx_st <= w_tx_nx;
            if (w_tx_pop) begin
                r_tx_sh  <= w_tx_dout;
                r_tx_n   <= eff_baud(r_baud);
                r_tx_cnt <= '0;
                r_tx_bit <= '0;
            end else if (r_tx_st != S_IDLE) begin
                r_tx_cnt <= w_tx_tick ? '0 : r_tx_cnt + 16'd1;
                if (w_tx_tick && r_tx_st == S_DATA) begin
                    r_tx_sh  <= r_tx_sh >> 1;
                    r_tx_bit <= r_tx_bit + 3'd1;
                end
            end
        end
    end
    uart_state_t r_rx_st, w_rx_nx;
    logic [15:0] r_rx_cnt, r_rx_n;
    logic [2:0]  r_rx_bit;
    logic [7:0]  r_rx_sh;
    logic        r_rx_s1, r_rx_s2, r_rx_wait;
    logic        w_rx_tick, w_rx_half;
    assign w_rx_tick = r_rx_cnt == r_rx_n - 16'd1;
    assign w_rx_half = r_rx_cnt == (r_rx_n >> 1) - 16'd1;
    always_comb begin
        w_rx_nx   = r_rx_st;
        w_rx_push = 1'b0;
        w_rx_ferr = 1'b0;
        case (r_rx_st)
            S_IDLE:  if (r_ctrl[CTRL_RX_EN] && !r_rx_wait && !r_rx_s2) w_rx_nx = S_START;
            S_START: if (w_rx_half) w_rx_nx = r_rx_s2 ? S_IDLE : S_DATA;
            S_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_nx = S_STOP;
            S_STOP:  if (w_rx_tick) begin w_rx_nx = S_IDLE; w_rx_push = r_rx_s2; w_rx_ferr = !r_rx_s2; end
            default: w_rx_nx = S_IDLE;
        endcase
    end
    // after a framing error the line must return high before a new start bit is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_st   <= S_IDLE;
            r_rx_wait <= 1'b0;
            r_rx_cnt  <= '0;
            r_rx_n    <= eff_baud(BAUD_RST);
            r_rx_bit  <= '0;
            r_rx_sh   <= '0;
        end else begin
            r_rx_s1   <= rx_pin;
            r_rx_s2   <= r_rx_s1;
            r_rx_st   <= w_rx_nx;
            r_rx_wait <= w_rx_ferr | (r_rx_wait & !r_rx_s2);
            if (r_rx_st == S_IDLE) begin
                r_rx_cnt <= '0;
                r_rx_bit <= '0;
                r_rx_n   <= eff_baud(r_baud);
            end else begin
                r_rx_cnt <= (w_rx_tick || (r_rx_st == S_START && w_rx_half)) ? '0 : r_rx_cnt + 16'd1;
                if (w_rx_tick && r_rx_st == S_DATA) begin
                    r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
                    r_rx_bit <= r_rx_bit + 3'd1;
                end
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl <= '0;
            r_baud <= BAUD_RST;
            r_ovr  <= 1'b0;
            r_ferr <= 1'b0;
            r_irq  <= 1'b0;
        end else begin
            if (we_i && w_addr == UART_CTRL) r_ctrl <= data_i[3:0];
            if (we_i && w_addr == UART_BAUD) r_baud <= data_i[15:0];
            r_ovr  <= (r_ovr & !(w_wr_status & data_i[STAT_RX_OVERRUN])) | (w_rx_push & w_rx_full & !w_wr_rxpop);
            r_ferr <= (r_ferr & !(w_wr_status & data_i[STAT_FRAME_ERR])) | w_rx_ferr;
            r_irq  <= (!w_rx_empty & r_ctrl[CTRL_RX_IE]) | (w_tx_empty & r_ctrl[CTRL_TX_IE]);
        end
    end
    assign irq_o = r_irq;
    always_comb begin
        data_o = '0;
        case (w_addr)
            UART_CTRL:   data_o = {28'h0, r_ctrl};
            UART_STATUS: data_o = {26'h0, r_ferr, r_ovr, !w_rx_empty, w_tx_empty, w_tx_full, r_tx_st != S_IDLE};
            UART_BAUD:   data_o = {16'h0, r_baud};
            UART_RXDATA: data_o = w_rx_empty ? 32'h0 : {24'h0, w_rx_dout};
            default:     data_o = '0;
        endcase
    end
endmodule

// File: tb/tb_rib_uart.sv
// tb_rib_uart: directed scoreboard bench for rib_uart covering registers, TX timing, RX, FIFO limits and errors.
module tb_rib_uart;
    import rib_uart_pkg::*;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] data_o;
    logic        tx_pin;
    logic        rx_pin;
    logic        irq_o;
    logic        rx_drv;
    logic        loop;
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  txq[$];
    logic [7:0]  rxq[$];
    logic [7:0]  rx_bytes[5] = '{8'h01, 8'h80, 8'h5A, 8'hFF, 8'h77};
    logic [7:0]  tx_bytes[5] = '{8'h11, 8'hE2, 8'h0F, 8'h96, 8'h4B};
    assign rx_pin = loop ? tx_pin : rx_drv;
    always #5 clk = ~clk;
    rib_uart dut (
        .clk(clk), .rst(rst), .addr_i(addr), .data_i(wdata), .we_i(we),
        .data_o(data_o), .tx_pin(tx_pin), .rx_pin(rx_pin), .irq_o(irq_o)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = 32'(a);
        wdata = d;
        we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask
    task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
        addr = 32'(a);
        #1;
        chk(tag, data_o, exp);
    endtask
    // compares tx_pin at the first and last clock of every bit period against queued bytes
    task automatic tx_watch(input int nframes, input int n);
        logic [7:0] b;
        logic       e;
        int         bi;
        for (int f = 0; f < nframes; f++) begin
            b = txq.pop_front();
            for (int k = 0; k < 10 * n; k++) begin
                @(negedge clk);
                bi = k / n;
                e = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : b[bi-1];
                if (k % n == 0 || k % n == n - 1) chk($sformatf("tx_f%0d_k%0d", f, k), 32'(tx_pin), 32'(e));
            end
        end
    endtask
    task automatic send_rx(input logic [7:0] b, input logic stop);
        rx_drv = 1'b0;
        cyc(8);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            cyc(8);
        end
        rx_drv = stop;
        cyc(8);
        rx_drv = 1'b1;
        cyc(4);
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
    initial begin
        int wait_n;
        rst = 1'b1; we = 1'b0; addr = '0; wdata = '0; rx_drv = 1'b1; loop = 1'b0;
        cyc(3);
        rst = 1'b0;
        rd("rst_status", UART_STATUS, 32'h4);
        rd("rst_baud", UART_BAUD, 32'd434);
        rd("rst_ctrl", UART_CTRL, 32'h0);
        rd("unmapped", 8'h18, 32'h0);
        rd("rst_rxdata", UART_RXDATA, 32'h0);
        chk("rst_tx_pin", 32'(tx_pin), 32'd1);
        chk("rst_irq", 32'(irq_o), 32'd0);
        wr(UART_CTRL, 32'h8);
        cyc(1);
        chk("irq_tx_empty", 32'(irq_o), 32'd1);
        wr(UART_CTRL, 32'h0);
        cyc(1);
        chk("irq_off", 32'(irq_o), 32'd0);
        wr(UART_BAUD, 32'd2);
        rd("baud_small", UART_BAUD, 32'd2);
        wr(UART_BAUD, 32'd8);
        wr(UART_CTRL, 32'h1);
        txq.push_back(8'hA5);
        wr(UART_TXDATA, 32'hA5);
        chk("tx_idle_at_write", 32'(tx_pin), 32'd1);
        tx_watch(1, 8);
        rd("busy_last_stop", UART_STATUS, 32'h5);
        cyc(1);
        rd("busy_fell", UART_STATUS, 32'h4);
        wr(UART_CTRL, 32'h0);
        for (int i = 0; i < 5; i++) begin
            if (txq.size() < 4) txq.push_back(tx_bytes[i]);
            wr(UART_TXDATA, 32'(tx_bytes[i]));
        end
        rd("tx_full", UART_STATUS, 32'h2);
        wr(UART_CTRL, 32'h1);
        tx_watch(4, 8);
        cyc(1);
        chk("tx_after_burst", 32'(tx_pin), 32'd1);
        rd("fifth_dropped", UART_STATUS, 32'h4);
        wr(UART_CTRL, 32'h7);
        loop = 1'b1;
        rxq.push_back(8'h3C);
        wr(UART_TXDATA, 32'h3C);
        wait_n = 0;
        while (!irq_o && wait_n < 300) begin
            @(negedge clk);
            wait_n++;
        end
        chk("irq_rx_rise", 32'(irq_o), 32'd1);
        rd("loop_rxdata", UART_RXDATA, 32'(rxq.pop_front()));
        rd("rx_nonempty", UART_STATUS, 32'h0C);
        wr(UART_RXPOP, 32'h0);
        rd("rx_popped", UART_STATUS, 32'h04);
        cyc(1);
        chk("irq_rx_clear", 32'(irq_o), 32'd0);
        cyc(20);
        loop = 1'b0;
        wr(UART_CTRL, 32'h2);
        for (int i = 0; i < 5; i++) begin
            if (rxq.size() < 4) rxq.push_back(rx_bytes[i]);
            send_rx(rx_bytes[i], 1'b1);
        end
        rd("overrun_set", UART_STATUS, 32'h1C);
        wr(UART_STATUS, 32'h10);
        rd("overrun_w1c", UART_STATUS, 32'h0C);
        for (int i = 0; i < 4; i++) begin
            rd($sformatf("rx_fifo_%0d", i), UART_RXDATA, 32'(rxq.pop_front()));
            wr(UART_RXPOP, 32'h0);
        end
        rd("rx_drained", UART_RXDATA, 32'h0);
        rx_drv = 1'b0;
        cyc(2);
        rx_drv = 1'b1;
        cyc(30);
        rd("glitch_no_push", UART_STATUS, 32'h4);
        send_rx(8'h55, 1'b0);
        cyc(10);
        rd("frame_err", UART_STATUS, 32'h24);
        wr(UART_STATUS, 32'h20);
        rd("frame_err_w1c", UART_STATUS, 32'h4);
        rxq.push_back(8'h81);
        send_rx(8'h81, 1'b1);
        rd("rx_recover", UART_RXDATA, 32'(rxq.pop_front()));
        wr(UART_RXPOP, 32'h0);
        wr(UART_CTRL, 32'h1);
        wr(UART_TXDATA, 32'h00);
        cyc(20);
        chk("tx_mid_frame_low", 32'(tx_pin), 32'd0);
        #2 rst = 1'b1;
        #1 chk("tx_async_reset", 32'(tx_pin), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        rd("post_rst_status", UART_STATUS, 32'h4);
        rd("post_rst_baud", UART_BAUD, 32'd434);
        rd("post_rst_ctrl", UART_CTRL, 32'h0);
        chk("post_rst_irq", 32'(irq_o), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
